// File: rtl/ram_port_pkg.sv
// Shared encodings for the RAM load/store port: access sizes, FSM states,
// and helpers that decode a request's alignment and store byte lanes.
package ram_port_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_e;

    // Size 3, odd halfword offsets and any non-zero word offset are errors.
    function automatic logic size_addr_err(input size_e size, input logic [1:0] ofs);
        logic err;
        err = 1'b1;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = ofs[0];
            SZ_WORD: err = (ofs != 2'd0);
            SZ_ILL:  err = 1'b1;
        endcase
        return err;
    endfunction

    // Active-low byte-lane write enables for an aligned, error-free store.
    function automatic logic [3:0] store_wen(input size_e size, input logic [1:0] ofs);
        logic [3:0] wen;
        wen = 4'hF;
        case (size)
            SZ_BYTE: wen[ofs] = 1'b0;
            SZ_HALF: begin
                wen[{ofs[1], 1'b0}] = 1'b0;
                wen[{ofs[1], 1'b1}] = 1'b0;
            end
            SZ_WORD: wen = 4'h0;
            SZ_ILL:  wen = 4'hF;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/ram_port_fmt.sv
// Load formatter: aligns the addressed byte/half/word of a RAM word to bit 0
// and zero- or sign-extends it. Purely combinational.
module ram_port_fmt
    import ram_port_pkg::*;
(
    input  logic [31:0] ram_dout,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        sign_byte;
    logic        sign_half;

    always_comb begin
        shifted   = ram_dout >> {addr_lo, 3'b000};
        sign_byte = ~is_unsigned & shifted[7];
        sign_half = ~is_unsigned & shifted[15];
        rdata     = '0;
        case (size)
            SZ_BYTE: rdata = {{24{sign_byte}}, shifted[7:0]};
            SZ_HALF: rdata = {{16{sign_half}}, shifted[15:0]};
            SZ_WORD: rdata = shifted;
            SZ_ILL:  rdata = '0;
        endcase
    end

endmodule

// File: rtl/ram_port.sv
// Single-outstanding load/store port onto a 1-cycle synchronous-read RAM.
// Stores/errors respond 1 cycle after accept, loads 2; response held until rsp_ready.
module ram_port
    import ram_port_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [31:0]   ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [3:0]    ram_wen,
    input  logic [31:0]   ram_dout
);

    state_e      state_q, state_d;
    logic [1:0]  ofs_q, ofs_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    size_e       req_sz;
    logic        accept;
    logic        req_err;
    logic [31:0] fmt_rdata;
    logic        unused_addr_hi;

    assign req_sz    = size_e'(req_size);
    assign req_ready = (state_q == IDLE) && resetn;
    assign accept    = req_valid && req_ready;
    assign req_err   = size_addr_err(req_sz, req_addr[1:0]);

    // Word index only; bits above the RAM size wrap.
    assign ram_waddr      = req_addr[AW+1:2];
    assign ram_raddr      = req_addr[AW+1:2];
    assign unused_addr_hi = ^req_addr[31:AW+2];

    always_comb begin
        case (req_sz)
            SZ_BYTE: ram_din = {4{req_wdata[7:0]}};
            SZ_HALF: ram_din = {2{req_wdata[15:0]}};
            default: ram_din = req_wdata;
        endcase
    end

    always_comb begin
        ram_wen = 4'hF;
        if (accept && req_we && !req_err) begin
            ram_wen = store_wen(req_sz, req_addr[1:0]);
        end
    end

    ram_port_fmt u_fmt (
        .ram_dout    (ram_dout),
        .addr_lo     (ofs_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (fmt_rdata)
    );

    always_comb begin
        state_d = state_q;
        ofs_d   = ofs_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ofs_d   = req_addr[1:0];
                    size_d  = req_sz;
                    uns_d   = req_unsigned;
                    rdata_d = '0;
                    err_d   = req_err;
                    // RAM read was launched this cycle; good loads wait one cycle for ram_dout.
                    state_d = (req_we || req_err) ? RESP : DATA;
                end
            end
            DATA: begin
                rdata_d = fmt_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ofs_q   <= 2'd0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ofs_q   <= ofs_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/ram_port.md
RAM_PORT -- requirements
Module: ram_port

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit RAM words; AW = $clog2(DEPTH).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when high, sign-extends when low.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned or illegal-size request.
REQ-015 SHALL have ports ram_din  output  32, ram_waddr  output  AW, ram_raddr  output  AW, ram_wen  output  4 (active-low byte enables), ram_dout  input  32, connecting to a 1-cycle synchronous-read RAM.

Function
REQ-016 SHALL implement FSM states IDLE, DATA, RESP; req_ready = 1 only in IDLE with resetn high.
REQ-017 SHALL accept a request at a rising edge where req_valid & req_ready.
REQ-018 SHALL flag an error for size 3, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-019 SHALL drive ram_waddr = ram_raddr = req_addr[AW+1:2] combinationally; upper address bits ignored (wrap).
REQ-020 SHALL drive ram_din: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-021 SHALL drive ram_wen = 4'hF except during an accepting cycle for an error-free store: byte clears bit addr[1:0]; half clears bits {addr[1],0} and {addr[1],1}; word drives 4'h0.
REQ-022 SHALL transition IDLE->RESP on accepting a store or error request, rsp_valid high the next cycle (latency 1).
REQ-023 SHALL transition IDLE->DATA on accepting a good load, then DATA->RESP, registering formatted ram_dout; rsp_valid high 2 cycles after acceptance.
REQ-024 SHALL capture addr[1:0], size, unsigned at acceptance; the load formatter shifts ram_dout right by 8*addr[1:0] and extends from bit 7 (byte) or 15 (half).
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready; RESP->IDLE on rsp_valid & rsp_ready.
REQ-026 SHALL not accept a new request in DATA or RESP (max one outstanding; store throughput 1 per 2 cycles).
REQ-027 SHALL ignore req_* changes after acceptance.

Reset
REQ-028 SHALL, while resetn low: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0, ram_wen 4'hF.
REQ-029 SHALL discard an in-flight request on reset in DATA or RESP; no response after release.
REQ-030 SHALL not initialise RAM contents.

Structure
REQ-031 SHALL place size encodings and the FSM state enum in package ram_port_pkg.
REQ-032 SHALL isolate load extraction/extension in sub-module ram_port_fmt (combinational, inputs ram_dout, addr[1:0], size, unsigned).

Verification
REQ-033 Store word 0xDEADBEEF @0x10 -> ram_wen 4'h0, ram_waddr 4, rsp_valid next cycle, rsp_err 0, rsp_rdata 0.
REQ-034 Loads after REQ-033: byte @0x11 signed -> 0xFFFFFFBE; unsigned -> 0x000000BE; half @0x12 signed -> 0xFFFFDEAD; each rsp_valid 2 cycles after accept.
REQ-035 Store byte 0x5A @0x13 -> ram_wen 4'b0111, ram_din 0x5A5A5A5A; word load @0x10 -> 0x5AADBEEF.
REQ-036 Word load @0x06, and size 3 @0x00 -> rsp_err 1, rsp_rdata 0, latency 1, ram_wen stays 4'hF.
REQ-037 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0; accept resumes the cycle after the handshake.
REQ-038 resetn low for 1 cycle in DATA -> no rsp_valid after release, req_ready 1, outputs at reset values.
